// File: rtl/uart_mem_responder.sv
// Byte-stream memory responder: read/write commands arrive over an rx byte stream, responses leave
// on tx. Optional inter-byte timeout is enabled by defining UART_MEM_RESP_TIMEOUT_EN.
module uart_mem_responder #(
   parameter int unsigned Depth         = 256,
   parameter int unsigned TimeoutCycles = 1000000,
   parameter logic [7:0]  ReadCmd       = 8'h77
) (
   input  logic       clk_i,
   input  logic       reset_ni,
   input  logic [7:0] rx_tdata_i,
   input  logic       rx_tvalid_i,
   output logic       rx_tready_o,
   output logic [7:0] tx_tdata_o,
   output logic       tx_tvalid_o,
   input  logic       tx_tready_i,
   output logic       busy_o,
   output logic       err_o
);

   localparam int unsigned AW = $clog2(Depth);

   typedef enum logic [2:0] {StIdle, StCmdAddr, StWdata, StRdMem, StWrMem, StSend} state_e;

   state_e          state_q;
   logic            is_wr_q;
   logic [3:0]      wstrb_q;
   logic [AW-1:0]   idx_q;
   logic [31:0]     data_q;
   logic [1:0]      cnt_q;
   logic [1:0]      last_q;
   logic [31:0]     mem [Depth];
   logic            rx_fire;
   logic            tx_fire;
   logic            tmo_hit;

   assign rx_fire = rx_tvalid_i & rx_tready_o;
   assign tx_fire = tx_tvalid_o & tx_tready_i;

`ifdef UART_MEM_RESP_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TimeoutCycles + 1);
   logic [TW-1:0] tmo_q;
   logic          waiting;

   assign waiting = (state_q == StCmdAddr) || (state_q == StWdata);
   assign tmo_hit = waiting && !rx_fire && (tmo_q == TW'(TimeoutCycles - 1));

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         tmo_q <= '0;
      end else if (waiting && !rx_fire && !tmo_hit) begin
         tmo_q <= tmo_q + 1'b1;
      end else begin
         tmo_q <= '0;
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q     <= StIdle;
         is_wr_q     <= 1'b0;
         wstrb_q     <= 4'h0;
         idx_q       <= '0;
         data_q      <= 32'h0;
         cnt_q       <= 2'd0;
         last_q      <= 2'd0;
         rx_tready_o <= 1'b0;
         tx_tdata_o  <= 8'h00;
         tx_tvalid_o <= 1'b0;
         busy_o      <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         err_o <= 1'b0;
         if (tmo_hit) begin
            state_q     <= StIdle;
            busy_o      <= 1'b0;
            rx_tready_o <= 1'b1;
            err_o       <= 1'b1;
         end else begin
            unique case (state_q)
               StIdle: begin
                  rx_tready_o <= 1'b1;
                  if (rx_fire) begin
                     busy_o <= 1'b1;
                     cnt_q  <= 2'd0;
                     if (rx_tdata_i == ReadCmd) begin
                        state_q <= StCmdAddr;
                        is_wr_q <= 1'b0;
                     end else if (rx_tdata_i[7:4] == 4'h2) begin
                        state_q <= StCmdAddr;
                        is_wr_q <= 1'b1;
                        wstrb_q <= rx_tdata_i[3:0];
                     end else begin
                        state_q     <= StSend;
                        rx_tready_o <= 1'b0;
                        tx_tdata_o  <= 8'hEE;
                        tx_tvalid_o <= 1'b1;
                        last_q      <= 2'd0;
                        err_o       <= 1'b1;
                     end
                  end
               end
               StCmdAddr: begin
                  if (rx_fire) begin
                     // Keep only the word-index bits; address bit j+2 lives in byte (j+2)/8.
                     for (int j = 0; j < int'(AW); j++) begin
                        if ((j + 2) / 8 == int'(cnt_q)) idx_q[j] <= rx_tdata_i[(j + 2) % 8];
                     end
                     cnt_q <= cnt_q + 2'd1;
                     if (cnt_q == 2'd3) begin
                        state_q     <= is_wr_q ? StWdata : StRdMem;
                        rx_tready_o <= is_wr_q;
                     end
                  end
               end
               StWdata: begin
                  if (rx_fire) begin
                     data_q <= {rx_tdata_i, data_q[31:8]};
                     cnt_q  <= cnt_q + 2'd1;
                     if (cnt_q == 2'd3) begin
                        state_q     <= StWrMem;
                        rx_tready_o <= 1'b0;
                     end
                  end
               end
               StRdMem: begin
                  data_q      <= mem[idx_q];
                  tx_tdata_o  <= mem[idx_q][7:0];
                  tx_tvalid_o <= 1'b1;
                  last_q      <= 2'd3;
                  cnt_q       <= 2'd0;
                  state_q     <= StSend;
               end
               StWrMem: begin
                  tx_tdata_o  <= 8'hC8;
                  tx_tvalid_o <= 1'b1;
                  last_q      <= 2'd0;
                  cnt_q       <= 2'd0;
                  state_q     <= StSend;
               end
               StSend: begin
                  if (tx_fire) begin
                     if (cnt_q == last_q) begin
                        state_q     <= StIdle;
                        tx_tvalid_o <= 1'b0;
                        busy_o      <= 1'b0;
                        rx_tready_o <= 1'b1;
                     end else begin
                        cnt_q      <= cnt_q + 2'd1;
                        data_q     <= {8'h00, data_q[31:8]};
                        tx_tdata_o <= data_q[15:8];
                     end
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   // Memory is deliberately not reset; writes happen only from the WR_MEM state.
   always_ff @(posedge clk_i) begin
      if (state_q == StWrMem) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb_q[b]) mem[idx_q][8*b +: 8] <= data_q[8*b +: 8];
         end
      end
   end

endmodule
